// File: rtl/fmdwc_axis_if.sv
// rtl/fmdwc_axis_if.sv - AXI-Stream style handshake bundle used on both sides of the width converter
interface fmdwc_axis_if #(
  parameter int BITS = 8
) ();
  logic            tvalid;
  logic            tready;
  logic [BITS-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/fmdwc_axis.sv
// rtl/fmdwc_axis.sv - regroups a stream of ELEM_BITS elements from IN_SIMD to OUT_SIMD per beat
module fmdwc_axis #(
  parameter int IN_SIMD   = 4,
  parameter int OUT_SIMD  = 2,
  parameter int ELEM_BITS = 8,
  localparam int IN_BITS  = 8*(1+(IN_SIMD*ELEM_BITS-1)/8),
  localparam int OUT_BITS = 8*(1+(OUT_SIMD*ELEM_BITS-1)/8)
) (
  input  logic         ap_clk,
  input  logic         ap_rst_n,
  fmdwc_axis_if.slave  s_axis,
  fmdwc_axis_if.master m_axis
);
  localparam int IN_E  = IN_SIMD*ELEM_BITS;
  localparam int OUT_E = OUT_SIMD*ELEM_BITS;
  localparam bit UP    = OUT_SIMD > IN_SIMD;
  localparam int R     = UP ? OUT_SIMD/IN_SIMD : IN_SIMD/OUT_SIMD;
  localparam int CW    = (R > 1) ? $clog2(R) : 1;

  if ((UP ? OUT_SIMD % IN_SIMD : IN_SIMD % OUT_SIMD) != 0) begin : g_bad_ratio
    $error("fmdwc_axis: max(IN_SIMD,OUT_SIMD) must be a multiple of min(IN_SIMD,OUT_SIMD)");
  end

  logic [IN_E-1:0] s_elems;
  logic            s_ready;
  logic            s_fire;

  // Pad bits above the element field are dropped here.
  assign s_elems       = s_axis.tdata[IN_E-1:0];
  assign s_axis.tready = s_ready;
  assign s_fire        = s_axis.tvalid && s_ready;

  if (UP) begin : g_up
    logic [CW-1:0]         icnt_q, icnt_d;
    logic [(R-1)*IN_E-1:0] acc_q, acc_d;
    logic [OUT_E-1:0]      word_q, word_d;
    logic                  vld_q, vld_d;
    logic                  last;

    assign last = (icnt_q == CW'(R-1));
    // Only the closing beat of a group needs room in the output register.
    assign s_ready = ap_rst_n && (!last || !vld_q || m_axis.tready);

    // Collect filler beats; the closing beat completes the word straight into the output register.
    always_comb begin
      icnt_d = icnt_q;
      acc_d  = acc_q;
      word_d = word_q;
      vld_d  = vld_q;
      if (vld_q && m_axis.tready) begin
        vld_d = 1'b0;
      end
      if (s_fire) begin
        if (last) begin
          word_d = {s_elems, acc_q};
          vld_d  = 1'b1;
          icnt_d = '0;
        end else begin
          acc_d[int'(icnt_q)*IN_E +: IN_E] = s_elems;
          icnt_d = icnt_q + CW'(1);
        end
      end
    end

    // State registers; reset drops any partial group and any pending word.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        icnt_q <= '0;
        acc_q  <= '0;
        word_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        icnt_q <= icnt_d;
        acc_q  <= acc_d;
        word_q <= word_d;
        vld_q  <= vld_d;
      end
    end

    assign m_axis.tvalid = vld_q;
    assign m_axis.tdata  = OUT_BITS'(word_q);
  end else begin : g_down
    // Also covers pass-through: with R = 1 the chunk counter never leaves 0.
    logic [CW-1:0]   ocnt_q, ocnt_d;
    logic [IN_E-1:0] hold_q, hold_d;
    logic            vld_q, vld_d;
    logic            last;

    assign last = (ocnt_q == CW'(R-1));
    // A new word may enter in the same cycle the last chunk of the held one leaves.
    assign s_ready = ap_rst_n && (!vld_q || (last && m_axis.tready));

    // Step through the chunks of the held word; reload when the last chunk drains.
    always_comb begin
      ocnt_d = ocnt_q;
      hold_d = hold_q;
      vld_d  = vld_q;
      if (vld_q && m_axis.tready) begin
        if (last) begin
          ocnt_d = '0;
          vld_d  = 1'b0;
        end else begin
          ocnt_d = ocnt_q + CW'(1);
        end
      end
      if (s_fire) begin
        hold_d = s_elems;
        vld_d  = 1'b1;
      end
    end

    // State registers; reset discards the held word and its chunk position.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        ocnt_q <= '0;
        hold_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        ocnt_q <= ocnt_d;
        hold_q <= hold_d;
        vld_q  <= vld_d;
      end
    end

    assign m_axis.tvalid = vld_q;
    assign m_axis.tdata  = OUT_BITS'(hold_q[int'(ocnt_q)*OUT_E +: OUT_E]);
  end

  // Upstream must hold a stalled beat unchanged until it is taken.
  a_s_stable: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    (s_axis.tvalid && !s_axis.tready) |=> (s_axis.tvalid && $stable(s_axis.tdata)))
    else $error("fmdwc_axis: s_axis beat changed while stalled");
endmodule

// File: tb/tb_fmdwc_axis.sv
// tb/tb_fmdwc_axis.sv - scoreboard bench for fmdwc_axis in up, down and pass-through configurations
module tb_fmdwc_axis;
  localparam int NCFG = 6;
  localparam int CFG_IS [NCFG] = '{2, 4, 1, 2, 6, 3};
  localparam int CFG_OS [NCFG] = '{4, 2, 3, 6, 2, 3};
  localparam int CFG_EB [NCFG] = '{8, 8, 8, 3, 3, 3};
  localparam int N_RND_ELEMS = 2004;

  logic ap_clk;
  logic ap_rst_n;
  bit   rnd_go;
  int   n_cmp;
  int   n_bad;

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mkw(input int w);
    mkw = {8'(4*w+19), 8'(4*w+18), 8'(4*w+17), 8'(4*w+16)};
  endfunction

  // Configs 0..2 take directed stimulus from the main process; 3..5 run random traffic.
  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int IS = CFG_IS[g];
    localparam int OS = CFG_OS[g];
    localparam int EB = CFG_EB[g];
    localparam int IB = 8*(1+(IS*EB-1)/8);
    localparam int OB = 8*(1+(OS*EB-1)/8);
    localparam logic [OB-1:0] ELEM_MASK = {OB{1'b1}} >> (OB - OS*EB);

    fmdwc_axis_if #(.BITS(IB)) s_if ();
    fmdwc_axis_if #(.BITS(OB)) m_if ();

    fmdwc_axis #(.IN_SIMD(IS), .OUT_SIMD(OS), .ELEM_BITS(EB)) u_dut (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .s_axis   (s_if),
      .m_axis   (m_if)
    );

    logic [EB-1:0] exp_q [$];
    int            n_out;

    always @(negedge ap_clk) begin : p_sb
      logic [63:0] e;
      if (!ap_rst_n) begin
        exp_q.delete();
      end else begin
        if (m_if.tvalid && m_if.tready) begin
          for (int i = 0; i < OS; i++) begin
            e = (exp_q.size() != 0) ? 64'(exp_q.pop_front()) : 64'hDEAD_0000_0000_0000;
            check($sformatf("c%0d_elem", g), 64'(m_if.tdata[i*EB +: EB]), e);
          end
          check($sformatf("c%0d_pad", g), 64'(m_if.tdata & ~ELEM_MASK), 64'd0);
          n_out++;
        end
        if (s_if.tvalid && s_if.tready) begin
          for (int i = 0; i < IS; i++) exp_q.push_back(s_if.tdata[i*EB +: EB]);
        end
      end
    end

    if (g >= 3) begin : g_rnd
      localparam int NB = N_RND_ELEMS / IS;
      bit done;
      initial begin : p_drv
        int sent;
        bit fire;
        sent = 0;
        done = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        m_if.tready = 1'b0;
        wait (rnd_go);
        @(posedge ap_clk); #1;
        for (int cyc = 0; cyc < 20000 && sent < NB; cyc++) begin
          if (!s_if.tvalid && ($urandom_range(0, 1) == 1)) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = IB'($urandom);
          end
          m_if.tready = 1'($urandom_range(0, 1));
          @(negedge ap_clk);
          fire = s_if.tvalid && s_if.tready;
          @(posedge ap_clk); #1;
          if (fire) begin
            sent++;
            s_if.tvalid = 1'b0;
          end
        end
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge ap_clk);
        @(negedge ap_clk); #1;
        check($sformatf("c%0d_sent", g), 64'(sent), 64'(NB));
        check($sformatf("c%0d_nout", g), 64'(n_out), 64'(N_RND_ELEMS / OS));
        check($sformatf("c%0d_drained", g), 64'(exp_q.size()), 64'd0);
        done = 1'b1;
      end
    end
  end

  initial begin : p_main
    int w;
    int b;
    ap_rst_n = 1'b0;
    rnd_go   = 1'b0;
    g_cfg[0].s_if.tvalid = 1'b0; g_cfg[0].s_if.tdata = '0; g_cfg[0].m_if.tready = 1'b1;
    g_cfg[1].s_if.tvalid = 1'b0; g_cfg[1].s_if.tdata = '0; g_cfg[1].m_if.tready = 1'b1;
    g_cfg[2].s_if.tvalid = 1'b0; g_cfg[2].s_if.tdata = '0; g_cfg[2].m_if.tready = 1'b1;

    // Reset state and first cycle after release.
    #12;
    check("rst_up24_mvld", 64'(g_cfg[0].m_if.tvalid), 64'd0);
    check("rst_up24_srdy", 64'(g_cfg[0].s_if.tready), 64'd0);
    check("rst_dn42_mvld", 64'(g_cfg[1].m_if.tvalid), 64'd0);
    check("rst_dn42_srdy", 64'(g_cfg[1].s_if.tready), 64'd0);
    check("rst_up13_srdy", 64'(g_cfg[2].s_if.tready), 64'd0);
    @(negedge ap_clk); ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    check("rel_up24_srdy", 64'(g_cfg[0].s_if.tready), 64'd1);
    check("rel_dn42_srdy", 64'(g_cfg[1].s_if.tready), 64'd1);
    check("rel_up13_srdy", 64'(g_cfg[2].s_if.tready), 64'd1);
    check("rel_up24_mvld", 64'(g_cfg[0].m_if.tvalid), 64'd0);

    // Up 2->4: two beats make one word, valid one cycle after the closing beat.
    g_cfg[0].s_if.tvalid = 1'b1; g_cfg[0].s_if.tdata = 16'h0201;
    @(negedge ap_clk); check("up24_b0_rdy", 64'(g_cfg[0].s_if.tready), 64'd1);
    @(posedge ap_clk); #1; g_cfg[0].s_if.tdata = 16'h0403;
    @(negedge ap_clk);
    check("up24_b1_rdy", 64'(g_cfg[0].s_if.tready), 64'd1);
    check("up24_vld_pre", 64'(g_cfg[0].m_if.tvalid), 64'd0);
    @(posedge ap_clk); #1; g_cfg[0].s_if.tvalid = 1'b0;
    check("up24_vld_lat", 64'(g_cfg[0].m_if.tvalid), 64'd1);
    check("up24_word", 64'(g_cfg[0].m_if.tdata), 64'h0403_0201);
    @(posedge ap_clk); #1;
    check("up24_single", 64'(g_cfg[0].m_if.tvalid), 64'd0);

    // Down 4->2: one word, two chunks on consecutive cycles.
    g_cfg[1].s_if.tvalid = 1'b1; g_cfg[1].s_if.tdata = 32'h4433_2211;
    @(negedge ap_clk); check("dn42_rdy", 64'(g_cfg[1].s_if.tready), 64'd1);
    @(posedge ap_clk); #1; g_cfg[1].s_if.tvalid = 1'b0;
    check("dn42_c0_vld", 64'(g_cfg[1].m_if.tvalid), 64'd1);
    check("dn42_c0", 64'(g_cfg[1].m_if.tdata), 64'h2211);
    @(posedge ap_clk); #1;
    check("dn42_c1_vld", 64'(g_cfg[1].m_if.tvalid), 64'd1);
    check("dn42_c1", 64'(g_cfg[1].m_if.tdata), 64'h4433);
    @(posedge ap_clk); #1;
    check("dn42_idle", 64'(g_cfg[1].m_if.tvalid), 64'd0);

    // Down 4->2 continuous: input ready every 2nd cycle, output never idles.
    w = 0;
    for (int c = 0; c <= 16; c++) begin
      g_cfg[1].s_if.tvalid = (w < 8);
      g_cfg[1].s_if.tdata  = mkw(w);
      @(negedge ap_clk);
      if (c >= 1) check("dn42_nobubble", 64'(g_cfg[1].m_if.tvalid), 64'd1);
      check("dn42_rdy_pulse", 64'(g_cfg[1].s_if.tready), 64'(c % 2 == 0));
      if (g_cfg[1].s_if.tvalid && g_cfg[1].s_if.tready) w++;
      @(posedge ap_clk); #1;
    end
    g_cfg[1].s_if.tvalid = 1'b0;
    check("dn42_words", 64'(w), 64'd8);

    // Down 4->2: stall on chunk 1 for 5 cycles, then drain and reload together.
    @(posedge ap_clk); #1;
    g_cfg[1].s_if.tvalid = 1'b1; g_cfg[1].s_if.tdata = 32'hA4A3_A2A1;
    @(negedge ap_clk); check("dnst_a_rdy", 64'(g_cfg[1].s_if.tready), 64'd1);
    @(posedge ap_clk); #1; g_cfg[1].s_if.tdata = 32'hB4B3_B2B1;
    @(negedge ap_clk); check("dnst_rdy_oc0", 64'(g_cfg[1].s_if.tready), 64'd0);
    @(posedge ap_clk); #1; g_cfg[1].m_if.tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      check("dnst_hold_vld", 64'(g_cfg[1].m_if.tvalid), 64'd1);
      check("dnst_hold_data", 64'(g_cfg[1].m_if.tdata), 64'hA4A3);
      check("dnst_hold_rdy", 64'(g_cfg[1].s_if.tready), 64'd0);
      @(posedge ap_clk); #1;
    end
    g_cfg[1].m_if.tready = 1'b1;
    @(negedge ap_clk);
    check("dnst_rel_rdy", 64'(g_cfg[1].s_if.tready), 64'd1);
    check("dnst_rel_data", 64'(g_cfg[1].m_if.tdata), 64'hA4A3);
    @(posedge ap_clk); #1; g_cfg[1].s_if.tvalid = 1'b0;
    check("dnst_b0_vld", 64'(g_cfg[1].m_if.tvalid), 64'd1);
    check("dnst_b0", 64'(g_cfg[1].m_if.tdata), 64'hB2B1);
    repeat (2) @(posedge ap_clk); #1;

    // Up 1->3 with a blocked output: two fillers go in, then the closing beat waits.
    g_cfg[2].m_if.tready = 1'b0;
    b = 0;
    for (int c = 0; c < 8; c++) begin
      g_cfg[2].s_if.tvalid = 1'b1;
      g_cfg[2].s_if.tdata  = 8'(17 + b);
      @(negedge ap_clk);
      if (c >= 3) begin
        check("up13_hold_vld", 64'(g_cfg[2].m_if.tvalid), 64'd1);
        check("up13_hold_data", 64'(g_cfg[2].m_if.tdata), 64'h13_1211);
      end
      if (c >= 5) check("up13_rdy_low", 64'(g_cfg[2].s_if.tready), 64'd0);
      if (g_cfg[2].s_if.tvalid && g_cfg[2].s_if.tready) b++;
      @(posedge ap_clk); #1;
    end
    check("up13_accepted", 64'(b), 64'd5);
    g_cfg[2].m_if.tready = 1'b1;
    @(negedge ap_clk); check("up13_close_rdy", 64'(g_cfg[2].s_if.tready), 64'd1);
    @(posedge ap_clk); #1; g_cfg[2].s_if.tvalid = 1'b0;
    check("up13_w1_vld", 64'(g_cfg[2].m_if.tvalid), 64'd1);
    check("up13_w1", 64'(g_cfg[2].m_if.tdata), 64'h16_1514);
    @(posedge ap_clk); #1;
    check("up13_idle", 64'(g_cfg[2].m_if.tvalid), 64'd0);

    // Up 2->4: reset with a pending word and a partial group; neither may reappear.
    g_cfg[0].m_if.tready = 1'b0;
    g_cfg[0].s_if.tvalid = 1'b1; g_cfg[0].s_if.tdata = 16'h2221;
    @(posedge ap_clk); #1; g_cfg[0].s_if.tdata = 16'h2423;
    @(posedge ap_clk); #1; g_cfg[0].s_if.tdata = 16'h2625;
    @(posedge ap_clk); #1; g_cfg[0].s_if.tvalid = 1'b0;
    check("rstm_pre_vld", 64'(g_cfg[0].m_if.tvalid), 64'd1);
    #2; ap_rst_n = 1'b0;
    #1;
    check("rstm_mvld", 64'(g_cfg[0].m_if.tvalid), 64'd0);
    check("rstm_srdy", 64'(g_cfg[0].s_if.tready), 64'd0);
    @(negedge ap_clk); @(negedge ap_clk); ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    g_cfg[0].m_if.tready = 1'b1;
    g_cfg[0].s_if.tvalid = 1'b1; g_cfg[0].s_if.tdata = 16'h3231;
    @(posedge ap_clk); #1; g_cfg[0].s_if.tdata = 16'h3433;
    @(posedge ap_clk); #1; g_cfg[0].s_if.tvalid = 1'b0;
    check("rstm_first_vld", 64'(g_cfg[0].m_if.tvalid), 64'd1);
    check("rstm_first_word", 64'(g_cfg[0].m_if.tdata), 64'h3433_3231);
    @(posedge ap_clk); #1;
    check("rstm_idle", 64'(g_cfg[0].m_if.tvalid), 64'd0);
    check("q_up24_empty", 64'(g_cfg[0].exp_q.size()), 64'd0);
    check("q_dn42_empty", 64'(g_cfg[1].exp_q.size()), 64'd0);
    check("q_up13_empty", 64'(g_cfg[2].exp_q.size()), 64'd0);

    // Random traffic on 2->6, 6->2 and 3->3 with 3-bit elements.
    rnd_go = 1'b1;
    for (int i = 0; i < 40000 &&
         !(g_cfg[3].g_rnd.done && g_cfg[4].g_rnd.done && g_cfg[5].g_rnd.done); i++)
      @(posedge ap_clk);
    check("rnd_finished", 64'({g_cfg[3].g_rnd.done, g_cfg[4].g_rnd.done, g_cfg[5].g_rnd.done}),
          64'b111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
